imm_gen_stage: RTL and testbench

- Parametrised, registered immediate-generation stage for the decode cycle.
- Takes a full 32-bit RISC-V instruction plus an immediate-format select and produces the XLEN-wide immediate.
- Adds CSR-zimm and shift-amount formats, an illegal-select flag, a sideband tag, and a DEPTH-entry ready/valid buffer with flush, so decode can stall or kill independently of fetch.

---
 rtl/imm_gen_stage_pkg.sv | 23 ++
 rtl/imm_decode.sv | 41 ++++
 rtl/imm_gen_stage.sv | 98 +++++++++
 tb/tb_imm_gen_stage.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_stage_pkg.sv
// Shared encodings for the decode-stage immediate generator: format selects
// and the pointer-width helper used by the entry buffer.
package imm_gen_stage_pkg;

    typedef enum logic [2:0] {
        I_TYPE  = 3'd0,
        S_TYPE  = 3'd1,
        B_TYPE  = 3'd2,
        U_TYPE  = 3'd3,
        J_TYPE  = 3'd4,
        Z_TYPE  = 3'd5,
        SH_TYPE = 3'd6,
        BAD_SEL = 3'd7
    } imm_sel_e;

    localparam int SEL_W = 3;

    // A single-entry buffer still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate format mux: instruction word plus format
// select in, XLEN-wide immediate and undefined-select flag out.
module imm_decode
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    input  logic [SEL_W-1:0] sel,
    output logic [XLEN-1:0]  imm,
    output logic             illegal
);

    // The opcode field never contributes to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_sel_e'(sel))
            I_TYPE:  imm = XLEN'($signed(instr[31:20]));
            S_TYPE:  imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            B_TYPE:  imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                          instr[11:8], 1'b0}));
            U_TYPE:  imm = XLEN'($signed({instr[31:12], 12'b0}));
            J_TYPE:  imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                          instr[30:21], 1'b0}));
            Z_TYPE:  imm = XLEN'(instr[19:15]);
            SH_TYPE: begin
                if (XLEN == 64) begin
                    imm = XLEN'(instr[25:20]);
                end else begin
                    imm = XLEN'(instr[24:20]);
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes the immediate at push time
// and holds {imm, illegal, tag} in a small ready/valid circular buffer.
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [SEL_W-1:0] in_imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  imm_mem     [DEPTH];
    logic             illegal_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem     [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;
    logic             push;
    logic             pop;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (in_instr),
        .sel     (in_imm_sel),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    // Explicit wrap keeps non-power-of-two depths inside the storage range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Readiness looks only at occupancy, so a full buffer refuses a push
    // even in a cycle where the consumer is draining it.
    assign in_ready    = reset & (count < CNT_W'(DEPTH));
    assign out_valid   = (count != '0);
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;

    assign out_imm     = imm_mem[rd_ptr];
    assign out_illegal = illegal_mem[rd_ptr];
    assign out_tag     = tag_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_mem[i]     <= '0;
                illegal_mem[i] <= 1'b0;
                tag_mem[i]     <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                imm_mem[wr_ptr]     <= dec_imm;
                illegal_mem[wr_ptr] <= dec_illegal;
                tag_mem[wr_ptr]     <= in_tag;
                wr_ptr              <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: a 32-bit/depth-2 and a 64-bit/depth-3 instance
// checked against directed vectors, corner sequences and a queue model.
module tb_imm_gen_stage;
    import imm_gen_stage_pkg::*;

    typedef struct {
        bit          use64;
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [63:0] imm;
        bit          ill;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        bit          ill;
        logic [31:0] tag;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush      [2];
    logic        in_valid   [2];
    logic        out_ready  [2];
    logic [31:0] in_instr   [2];
    logic [2:0]  in_imm_sel [2];
    logic [31:0] in_tag     [2];

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm, a_out_tag;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm;
    logic [31:0] b_out_tag;

    int     n_compared = 0;
    int     n_failed   = 0;
    vec_t   vecs[$];
    entry_t q0[$];
    entry_t q1[$];

    imm_gen_stage #(.XLEN(32), .DEPTH(2), .TAG_W(32)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush[0]),
        .in_valid    (in_valid[0]),
        .in_ready    (a_in_ready),
        .in_instr    (in_instr[0]),
        .in_imm_sel  (in_imm_sel[0]),
        .in_tag      (in_tag[0]),
        .out_valid   (a_out_valid),
        .out_ready   (out_ready[0]),
        .out_imm     (a_out_imm),
        .out_illegal (a_out_illegal),
        .out_tag     (a_out_tag)
    );

    imm_gen_stage #(.XLEN(64), .DEPTH(3), .TAG_W(32)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush[1]),
        .in_valid    (in_valid[1]),
        .in_ready    (b_in_ready),
        .in_instr    (in_instr[1]),
        .in_imm_sel  (in_imm_sel[1]),
        .in_tag      (in_tag[1]),
        .out_valid   (b_out_valid),
        .out_ready   (out_ready[1]),
        .out_imm     (b_out_imm),
        .out_illegal (b_out_illegal),
        .out_tag     (b_out_tag)
    );

    initial forever #5 clk = ~clk;

    function automatic logic ready_of(input int d);
        return (d == 0) ? a_in_ready : b_in_ready;
    endfunction
    function automatic logic valid_of(input int d);
        return (d == 0) ? a_out_valid : b_out_valid;
    endfunction
    function automatic logic ill_of(input int d);
        return (d == 0) ? a_out_illegal : b_out_illegal;
    endfunction
    function automatic logic [63:0] imm_of(input int d);
        return (d == 0) ? {32'h0, a_out_imm} : b_out_imm;
    endfunction
    function automatic logic [31:0] tag_of(input int d);
        return (d == 0) ? a_out_tag : b_out_tag;
    endfunction

    // Field extraction by shifts and weights, then two's-complement fold.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int sel,
                                            input int xlen, output bit ill);
        longint u, v;
        int     w;
        bit     sx;
        u = longint'(ins);
        v = 0; w = 1; sx = 1'b0; ill = 1'b0;
        case (sel)
            0: begin v = (u >> 20) & 4095; w = 12; sx = 1'b1; end
            1: begin v = ((u >> 25) & 127) * 32 + ((u >> 7) & 31); w = 12; sx = 1'b1; end
            2: begin
                v = ((u >> 31) & 1) * 4096 + ((u >> 7) & 1) * 2048
                  + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
                w = 13; sx = 1'b1;
            end
            3: begin v = ((u >> 12) & 1048575) * 4096; w = 32; sx = 1'b1; end
            4: begin
                v = ((u >> 31) & 1) * 1048576 + ((u >> 12) & 255) * 4096
                  + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
                w = 21; sx = 1'b1;
            end
            5: v = (u >> 15) & 31;
            6: v = (u >> 20) & ((xlen == 64) ? 63 : 31);
            default: ill = 1'b1;
        endcase
        if (sx && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        if (xlen == 32) return {32'h0, v[31:0]};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [31:0] instr, input logic [2:0] sel,
                                 input logic [31:0] tag, input bit valid, input bit rdy,
                                 input bit fl);
        in_instr[d]   = instr;
        in_imm_sel[d] = sel;
        in_tag[d]     = tag;
        in_valid[d]   = valid;
        out_ready[d]  = rdy;
        flush[d]      = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string pfx, input bit exp_ready);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s%0d_in_ready", pfx, d), 64'(ready_of(d)), 64'(exp_ready));
            checkOutput($sformatf("%s%0d_out_valid", pfx, d), 64'(valid_of(d)), 64'd0);
            checkOutput($sformatf("%s%0d_out_imm", pfx, d), imm_of(d), 64'd0);
            checkOutput($sformatf("%s%0d_out_illegal", pfx, d), 64'(ill_of(d)), 64'd0);
            checkOutput($sformatf("%s%0d_out_tag", pfx, d), 64'(tag_of(d)), 64'd0);
        end
    endtask

    // Occupancy/order model: compare against the head, then apply this cycle.
    task automatic scoreDut(input int d);
        entry_t head, e;
        int     depth, sz, xl;
        bit     do_push, do_pop, ill;
        depth = (d == 0) ? 2 : 3;
        xl    = (d == 0) ? 32 : 64;
        sz    = (d == 0) ? q0.size() : q1.size();
        checkOutput($sformatf("rnd%0d_in_ready", d), 64'(ready_of(d)), 64'(sz < depth));
        checkOutput($sformatf("rnd%0d_out_valid", d), 64'(valid_of(d)), 64'(sz != 0));
        if (sz != 0) begin
            head = (d == 0) ? q0[0] : q1[0];
            checkOutput($sformatf("rnd%0d_out_imm", d), imm_of(d), head.imm);
            checkOutput($sformatf("rnd%0d_out_illegal", d), 64'(ill_of(d)), 64'(head.ill));
            checkOutput($sformatf("rnd%0d_out_tag", d), 64'(tag_of(d)), 64'(head.tag));
        end
        do_pop  = (sz != 0) && out_ready[d];
        do_push = in_valid[d] && (sz < depth);
        e.imm   = ref_imm(in_instr[d], int'(in_imm_sel[d]), xl, ill);
        e.ill   = ill;
        e.tag   = in_tag[d];
        if (flush[d]) begin
            if (d == 0) q0.delete(); else q1.delete();
        end else begin
            if (do_pop) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (do_push) begin
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
    endtask

    initial begin
        logic [31:0] w_instr [10];
        logic [2:0]  w_sel   [10];
        bit          ill;
        int          d;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus(i, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        vecs.push_back('{1'b0, 32'hFFF00093, I_TYPE,  64'h00000000FFFFFFFF, 1'b0});
        vecs.push_back('{1'b0, 32'hFE112E23, S_TYPE,  64'h00000000FFFFFFFC, 1'b0});
        vecs.push_back('{1'b0, 32'hFE000EE3, B_TYPE,  64'h00000000FFFFFFFC, 1'b0});
        vecs.push_back('{1'b0, 32'h12345037, U_TYPE,  64'h0000000012345000, 1'b0});
        vecs.push_back('{1'b0, 32'h001000EF, J_TYPE,  64'h0000000000000800, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFF8073, Z_TYPE,  64'h000000000000001F, 1'b0});
        vecs.push_back('{1'b0, 32'h03F00013, SH_TYPE, 64'h000000000000001F, 1'b0});
        vecs.push_back('{1'b0, 32'hFFFFFFFF, BAD_SEL, 64'h0000000000000000, 1'b1});
        vecs.push_back('{1'b1, 32'h800000B7, U_TYPE,  64'hFFFFFFFF80000000, 1'b0});
        vecs.push_back('{1'b1, 32'h03F00013, SH_TYPE, 64'h000000000000003F, 1'b0});
        vecs.push_back('{1'b1, 32'h80000013, I_TYPE,  64'hFFFFFFFFFFFFF800, 1'b0});
        vecs.push_back('{1'b1, 32'h8000006F, J_TYPE,  64'hFFFFFFFFFFF00000, 1'b0});
        vecs.push_back('{1'b1, 32'h12345678, BAD_SEL, 64'h0000000000000000, 1'b1});

        #2 reset = 1'b0;
        tick();
        checkIdle("rst", 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("rst_release_ready_a", 64'(a_in_ready), 64'd1);
        checkOutput("rst_release_ready_b", 64'(b_in_ready), 64'd1);

        $display("[TB] directed format vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            d = vecs[i].use64 ? 1 : 0;
            checkOutput($sformatf("tbl%0d_pre_valid", i), 64'(valid_of(d)), 64'd0);
            applyStimulus(d, vecs[i].instr, vecs[i].sel, 32'hC0 + i, 1'b1, 1'b0, 1'b0);
            tick();
            applyStimulus(d, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("tbl%0d_valid", i), 64'(valid_of(d)), 64'd1);
            checkOutput($sformatf("tbl%0d_imm", i), imm_of(d), vecs[i].imm);
            checkOutput($sformatf("tbl%0d_illegal", i), 64'(ill_of(d)), 64'(vecs[i].ill));
            checkOutput($sformatf("tbl%0d_tag", i), 64'(tag_of(d)), 64'(32'hC0 + i));
            tick();
            applyStimulus(d, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        end

        $display("[TB] depth-2 backpressure");
        applyStimulus(0, 32'h0, I_TYPE, 32'hA1, 1'b1, 1'b0, 1'b0);
        checkOutput("fill_ready0", 64'(a_in_ready), 64'd1);
        tick();
        applyStimulus(0, 32'h0, I_TYPE, 32'hA2, 1'b1, 1'b0, 1'b0);
        checkOutput("fill_ready1", 64'(a_in_ready), 64'd1);
        checkOutput("fill_head1", 64'(a_out_tag), 64'hA1);
        tick();
        applyStimulus(0, 32'h0, I_TYPE, 32'hA3, 1'b1, 1'b0, 1'b0);
        checkOutput("fill_full_ready", 64'(a_in_ready), 64'd0);
        tick();
        applyStimulus(0, 32'h0, I_TYPE, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("fill_still_full", 64'(a_in_ready), 64'd0);
        checkOutput("fill_head_a1", 64'(a_out_tag), 64'hA1);
        tick();
        checkOutput("fill_ready_after_pop", 64'(a_in_ready), 64'd1);
        checkOutput("fill_head_a2", 64'(a_out_tag), 64'hA2);
        checkOutput("fill_valid_a2", 64'(a_out_valid), 64'd1);
        tick();
        applyStimulus(0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("fill_third_dropped", 64'(a_out_valid), 64'd0);

        $display("[TB] depth-3 streaming wrap");
        for (int k = 0; k < 10; k++) begin
            w_instr[k] = $urandom;
            w_sel[k]   = 3'($urandom_range(0, 6));
            applyStimulus(1, w_instr[k], w_sel[k], 32'h100 + k, 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("wrap%0d_ready", k), 64'(b_in_ready), 64'd1);
            if (k > 0) begin
                checkOutput($sformatf("wrap%0d_valid", k), 64'(b_out_valid), 64'd1);
                checkOutput($sformatf("wrap%0d_tag", k), 64'(b_out_tag), 64'(32'h100 + k - 1));
                checkOutput($sformatf("wrap%0d_imm", k), b_out_imm,
                            ref_imm(w_instr[k-1], int'(w_sel[k-1]), 64, ill));
            end
            tick();
        end
        applyStimulus(1, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("wrap_last_tag", 64'(b_out_tag), 64'h109);
        tick();
        applyStimulus(1, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap_drained", 64'(b_out_valid), 64'd0);

        $display("[TB] flush with simultaneous push");
        applyStimulus(1, 32'h0, I_TYPE, 32'h201, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1, 32'h0, I_TYPE, 32'h202, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1, 32'h0, I_TYPE, 32'h203, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_pre_head", 64'(b_out_tag), 64'h201);
        tick();
        applyStimulus(1, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_valid", 64'(b_out_valid), 64'd0);
        checkOutput("flush_ready", 64'(b_in_ready), 64'd1);
        tick();
        checkOutput("flush_push_lost", 64'(b_out_valid), 64'd0);
        applyStimulus(1, 32'h00500093, I_TYPE, 32'h204, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_after_tag", 64'(b_out_tag), 64'h204);
        checkOutput("flush_after_imm", b_out_imm, 64'd5);
        tick();
        applyStimulus(1, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] randomized traffic against queue model");
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                applyStimulus(i, $urandom, 3'($urandom_range(0, 7)), $urandom,
                              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                              $urandom_range(0, 19) == 0);
            end
            scoreDut(0);
            scoreDut(1);
            tick();
        end

        $display("[TB] reset in the middle of traffic");
        for (int i = 0; i < 2; i++) applyStimulus(i, 32'hFFF00093, I_TYPE, 32'h301 + i, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) applyStimulus(i, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checkIdle("midrst", 1'b0);
        tick();
        checkIdle("midrst_hold", 1'b0);
        reset = 1'b1;
        #1;
        checkIdle("postrst", 1'b1);
        applyStimulus(0, 32'h00A00093, I_TYPE, 32'h3AA, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("postrst_tag", 64'(a_out_tag), 64'h3AA);
        checkOutput("postrst_imm", imm_of(0), 64'd10);
        tick();
        applyStimulus(0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("postrst_empty", 64'(a_out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
